// File: rtl/elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_car_ctrl
// Single-car elevator controller with a SCAN (sweep) service policy.
// Car-panel and hall requests are merged into one pending-floor bitmask; the
// car sweeps in one direction, stopping at every pending floor, and reverses
// only when nothing is left ahead. Travel between adjacent floors takes
// TRAVEL_CYCLES clocks and every stop holds the door open for DOOR_CYCLES.
//
// Optional build macro: EMERGENCY_RECALL_EN
//   Adds a level input 'recall'. While high, all requests are dropped, the car
//   completes its current floor step, returns to DEFAULT_FLOOR and holds the
//   door open there until recall falls, after which a normal dwell runs.
//
// Ports:
//   clk             system clock
//   reset           asynchronous active-low reset
//   recall          emergency recall level (EMERGENCY_RECALL_EN only)
//   car_req_valid   car-panel request strobe
//   car_req_floor   car-panel requested floor
//   hall_req_valid  hall-call request strobe
//   hall_req_floor  hall-call requested floor
//   current_floor   floor the car is at or last passed
//   up_ndown        sweep direction, 1 = up
//   moving          high while travelling
//   door_open       high while the door is open
//   arrived         one-cycle pulse on the edge the car stops at a floor
//   pending         outstanding-request bitmask
//   req_error       one-cycle pulse after a request for a non-existent floor
// -----------------------------------------------------------------------------
module elevator_car_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int DEFAULT_FLOOR = 0,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef EMERGENCY_RECALL_EN
  input  logic                  recall,
`endif
  input  logic                  car_req_valid,
  input  logic [FLOOR_W-1:0]    car_req_floor,
  input  logic                  hall_req_valid,
  input  logic [FLOOR_W-1:0]    hall_req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  up_ndown,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_error
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] HOME        = FLOOR_W'(DEFAULT_FLOOR);
  localparam logic [FLOOR_W-1:0] TOP         = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, DOOR_OPEN = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;   // shared travel / dwell counter

  logic recall_act;
`ifdef EMERGENCY_RECALL_EN
  assign recall_act = recall;
`else
  assign recall_act = 1'b0;
`endif

  // Request qualification; recall silences both capture and error reporting.
  logic car_in_range, hall_in_range, car_ok, hall_ok, req_bad;
  assign car_in_range  = int'(car_req_floor) < NUM_FLOORS;
  assign hall_in_range = int'(hall_req_floor) < NUM_FLOORS;
  assign car_ok        = car_req_valid && car_in_range && !recall_act;
  assign hall_ok       = hall_req_valid && hall_in_range && !recall_act;
  assign req_bad       = !recall_act &&
                         ((car_req_valid && !car_in_range) || (hall_req_valid && !hall_in_range));

  logic [FLOOR_W-1:0] step_floor;
  assign step_floor = up_ndown ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);

  logic [NUM_FLOORS-1:0] new_mask, cur_hot, step_hot, above, below;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign new_mask[gi] = (car_ok  && car_req_floor  == FLOOR_W'(gi)) ||
                            (hall_ok && hall_req_floor == FLOOR_W'(gi));
      assign cur_hot[gi]  = current_floor == FLOOR_W'(gi);
      assign step_hot[gi] = step_floor == FLOOR_W'(gi);
      assign above[gi]    = pending[gi] && (FLOOR_W'(gi) > current_floor);
      assign below[gi]    = pending[gi] && (FLOOR_W'(gi) < current_floor);
    end
  endgenerate

  logic any_above, any_below, any_work, pend_here, pend_step, new_here;
  logic at_end, step_end, travel_done, home_up, step_home_up;
  assign any_above    = |above;
  assign any_below    = |below;
  assign any_work     = any_above || any_below;
  assign pend_here    = |(pending & cur_hot);
  assign pend_step    = |(pending & step_hot);
  assign new_here     = |(new_mask & cur_hot);
  assign at_end       = up_ndown ? (current_floor == TOP) : (current_floor == '0);
  assign step_end     = (step_floor == TOP) || (step_floor == '0);
  assign travel_done  = cnt == TRAVEL_LAST;
  assign home_up      = HOME > current_floor;
  assign step_home_up = HOME > step_floor;

  // Sweep direction: keep going while work lies ahead, otherwise turn around.
  logic dir_pick;
  always_comb begin
    dir_pick = up_ndown;
    if (up_ndown ? any_above : any_below)
      dir_pick = up_ndown;
    else if (up_ndown ? any_below : any_above)
      dir_pick = !up_ndown;
  end

  // Stops clear the serviced floor; a request for the floor whose door is
  // opening (or already open) is absorbed rather than left pending. A request
  // for a floor merely being passed survives for a later sweep.
  logic                  stop_idle, stop_step, absorb_door;
  logic [NUM_FLOORS-1:0] clr_mask, pending_next;
  assign stop_idle    = (state == IDLE) && !recall_act && pend_here;
  assign stop_step    = (state == MOVING) && travel_done && !at_end && !recall_act && pend_step;
  assign absorb_door  = (state == DOOR_OPEN) && new_here;
  assign clr_mask     = (stop_idle || absorb_door) ? cur_hot : (stop_step ? step_hot : '0);
  assign pending_next = recall_act ? '0 : ((pending | new_mask) & ~clr_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      current_floor <= HOME;
      up_ndown      <= 1'b1;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      arrived       <= 1'b0;
      pending       <= '0;
      req_error     <= 1'b0;
    end else begin
      pending   <= pending_next;
      req_error <= req_bad;
      arrived   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (recall_act) begin
            if (current_floor == HOME) begin
              state <= DOOR_OPEN; door_open <= 1'b1; arrived <= 1'b1;
            end else begin
              up_ndown <= home_up; state <= MOVING; moving <= 1'b1;
            end
          end else if (pend_here) begin
            state <= DOOR_OPEN; door_open <= 1'b1; arrived <= 1'b1;
          end else if (any_work) begin
            up_ndown <= dir_pick; state <= MOVING; moving <= 1'b1;
          end
        end
        MOVING: begin
          if (travel_done) begin
            cnt <= '0;
            if (at_end) begin
              // Would leave the shaft: abandon the move.
              state <= IDLE; moving <= 1'b0;
            end else begin
              current_floor <= step_floor;
              if (recall_act) begin
                if (step_floor == HOME) begin
                  state <= DOOR_OPEN; moving <= 1'b0; door_open <= 1'b1; arrived <= 1'b1;
                end else begin
                  up_ndown <= step_home_up;
                end
              end else if (pend_step) begin
                state <= DOOR_OPEN; moving <= 1'b0; door_open <= 1'b1; arrived <= 1'b1;
              end else if (step_end) begin
                // Reached the shaft end with nothing to do there.
                state <= IDLE; moving <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOOR_OPEN: begin
          if ((recall_act && current_floor == HOME) || new_here) begin
            cnt <= '0;  // hold at recall, or restart dwell on a fresh call here
          end else if (cnt == DOOR_LAST) begin
            cnt       <= '0;
            door_open <= 1'b0;
            if (recall_act) begin
              up_ndown <= home_up; state <= MOVING; moving <= 1'b1;
            end else if (any_work) begin
              up_ndown <= dir_pick; state <= MOVING; moving <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE; cnt <= '0; moving <= 1'b0; door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_car_ctrl
// Directed bench for elevator_car_ctrl (8 floors, 4-bit floor ports so that
// out-of-range floors can be requested). A request-level model of the car
// (pending set, countdown to next event, sweep rule) is stepped every clock and
// compared with all outputs on every falling edge; directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_elevator_car_ctrl;

  localparam int NF = 8;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 3;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          car_req_valid = 1'b0;
  logic [FW-1:0] car_req_floor = '0;
  logic          hall_req_valid = 1'b0;
  logic [FW-1:0] hall_req_floor = '0;
  logic [FW-1:0] current_floor;
  logic          up_ndown, moving, door_open, arrived, req_error;
  logic [NF-1:0] pending;

  elevator_car_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .DEFAULT_FLOOR(0),
    .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset),
    .car_req_valid(car_req_valid), .car_req_floor(car_req_floor),
    .hall_req_valid(hall_req_valid), .hall_req_floor(hall_req_floor),
    .current_floor(current_floor), .up_ndown(up_ndown), .moving(moving),
    .door_open(door_open), .arrived(arrived), .pending(pending),
    .req_error(req_error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int      m_floor;
  bit      m_up;
  int      m_mode;
  int      m_rem;     // clocks until the next travel/dwell event
  bit [NF-1:0] m_pend;
  bit      m_arr;
  bit      m_err;

  function automatic bit work_toward(bit [NF-1:0] p, int f, bit up);
    for (int i = 0; i < NF; i++)
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit sweep_dir(bit [NF-1:0] p, int f, bit up);
    if (work_toward(p, f, up)) return up;
    if (work_toward(p, f, !up)) return !up;
    return up;
  endfunction

  task automatic model_init();
    m_floor = 0; m_up = 1'b1; m_mode = M_IDLE; m_rem = 0;
    m_pend = '0; m_arr = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit [NF-1:0] newm;
    bit [NF-1:0] old;
    bit          err;
    newm = '0; err = 1'b0;
    if (car_req_valid) begin
      if (int'(car_req_floor) < NF) newm[car_req_floor[2:0]] = 1'b1; else err = 1'b1;
    end
    if (hall_req_valid) begin
      if (int'(hall_req_floor) < NF) newm[hall_req_floor[2:0]] = 1'b1; else err = 1'b1;
    end
    old    = m_pend;
    m_pend = m_pend | newm;
    m_arr  = 1'b0;
    m_err  = err;
    case (m_mode)
      M_IDLE: begin
        if (old[m_floor]) begin
          m_mode = M_DOOR; m_rem = DC; m_arr = 1'b1; m_pend[m_floor] = 1'b0;
        end else if (old != '0) begin
          m_up = sweep_dir(old, m_floor, m_up); m_mode = M_MOVE; m_rem = TC;
        end
      end
      M_MOVE: begin
        m_rem--;
        if (m_rem == 0) begin
          m_floor += m_up ? 1 : -1;
          if (old[m_floor]) begin
            m_mode = M_DOOR; m_rem = DC; m_arr = 1'b1; m_pend[m_floor] = 1'b0;
          end else if (m_floor == 0 || m_floor == NF - 1) begin
            m_mode = M_IDLE;
          end else begin
            m_rem = TC;
          end
        end
      end
      default: begin
        if (newm[m_floor]) begin
          m_pend[m_floor] = 1'b0; m_rem = DC;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            if (old != '0) begin
              m_up = sweep_dir(old, m_floor, m_up); m_mode = M_MOVE; m_rem = TC;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
      end
    endcase
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk);
      if (reset) model_step();
      else model_init();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("m_floor",   current_floor, m_floor);
        chk("m_dir",     up_ndown, m_up);
        chk("m_moving",  moving, m_mode == M_MOVE);
        chk("m_door",    door_open, m_mode == M_DOOR);
        chk("m_arrived", arrived, m_arr);
        chk("m_pending", pending, m_pend);
        chk("m_req_err", req_error, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one request cycle; returns at the falling edge after it was sampled.
  task automatic send(input bit cv, input int cf, input bit hv, input int hf);
    car_req_valid = cv; car_req_floor = FW'(cf);
    hall_req_valid = hv; hall_req_floor = FW'(hf);
    $display("req car=%0b/%0d hall=%0b/%0d t=%0t", cv, cf, hv, hf, $time);
    @(negedge clk);
    car_req_valid = 1'b0; hall_req_valid = 1'b0;
    car_req_floor = '0; hall_req_floor = '0;
  endtask

  task automatic wait_stop(input int f, input string name);
    for (int i = 0; i < 400; i++) begin
      if (door_open && current_floor == FW'(f)) break;
      @(negedge clk);
    end
    chk(name, door_open && current_floor == FW'(f), 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (!moving && !door_open && pending == '0) break;
      @(negedge clk);
    end
    chk(name, !moving && !door_open && pending == '0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    cycles(3);
    reset = 1'b1;

    // Idle after reset.
    cycles(20);
    chk("rst_floor",   current_floor, 0);
    chk("rst_dir",     up_ndown, 1);
    chk("rst_moving",  moving, 0);
    chk("rst_door",    door_open, 0);
    chk("rst_arrived", arrived, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err",     req_error, 0);

    // Floor 0 -> 3 latency.
    send(1, 3, 0, 0);                         // edge k
    chk("s2_pend_k", pending, 8'h08);
    chk("s2_idle_k", moving, 0);
    cycles(1);  chk("s2_move_k1", moving, 1);
    cycles(3);  chk("s2_floor_k4", current_floor, 0);
    cycles(1);  chk("s2_floor_k5", current_floor, 1);
    cycles(4);  chk("s2_floor_k9", current_floor, 2);
    cycles(4);
    chk("s2_floor_k13", current_floor, 3);
    chk("s2_door_k13",  door_open, 1);
    chk("s2_arr_k13",   arrived, 1);
    chk("s2_pend_k13",  pending, 0);
    chk("s2_stop_k13",  moving, 0);
    cycles(1);  chk("s2_arr_k14", arrived, 0); chk("s2_door_k14", door_open, 1);
    cycles(1);  chk("s2_door_k15", door_open, 1);
    cycles(1);  chk("s2_door_k16", door_open, 0); chk("s2_idle_k16", moving, 0);

    // Sweep up to 5 with 1 requested behind, then reverse.
    send(1, 0, 0, 0);
    wait_stop(0, "s3_stop0");
    wait_idle("s3_idle0");
    chk("s3_dir0", up_ndown, 0);
    send(1, 5, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (current_floor == FW'(2)) break;
      @(negedge clk);
    end
    chk("s3_at2_up", current_floor == FW'(2) && moving && up_ndown, 1);
    send(0, 0, 1, 1);
    chk("s3_pend51", pending, 8'b0010_0010);
    wait_stop(5, "s3_stop5");
    chk("s3_dir5", up_ndown, 1);
    for (int i = 0; i < 50; i++) begin
      if (!door_open) break;
      @(negedge clk);
    end
    chk("s3_reverse", {moving, up_ndown}, 2'b10);
    wait_stop(1, "s3_stop1");
    wait_idle("s3_idle1");
    chk("s3_floor1", current_floor, 1);

    // Same floor from car and hall: one bit, one stop.
    send(1, 4, 1, 4);
    chk("s4_pend", pending, 8'b0001_0000);
    wait_stop(4, "s4_stop4");
    wait_idle("s4_idle");
    chk("s4_floor4", current_floor, 4);

    // Out-of-range hall call.
    send(0, 0, 1, 9);
    chk("s5_err", req_error, 1);
    chk("s5_pend", pending, 0);
    cycles(1);
    chk("s5_err_drop", req_error, 0);

    // Call for the open-door floor restarts the dwell.
    send(1, 4, 0, 0);                         // edge k
    cycles(1);
    chk("s6_door_k1", door_open, 1);
    chk("s6_arr_k1", arrived, 1);
    send(0, 0, 1, 4);                         // edge k+2
    chk("s6_absorb", pending, 0);
    cycles(2);  chk("s6_restart_k4", door_open, 1);
    cycles(1);  chk("s6_close_k5", door_open, 0);

    // Call for the floor stepped onto on the same edge waits for the return.
    send(1, 7, 0, 0);                         // edge k
    cycles(4);
    send(0, 0, 1, 5);                         // edge k+5, car steps onto 5
    chk("s7_floor5", current_floor, 5);
    chk("s7_passing", moving, 1);
    chk("s7_pend", pending, 8'b1010_0000);
    wait_stop(7, "s7_stop7");
    wait_stop(5, "s7_stop5");
    wait_idle("s7_idle");

    // Reset in the middle of a move.
    send(1, 0, 0, 0);
    cycles(6);
    chk("s8_moving", moving, 1);
    #1;
    reset = 1'b0;
    model_init();
    #1;
    chk("s8_rst_floor", current_floor, 0);
    chk("s8_rst_moving", moving, 0);
    chk("s8_rst_pending", pending, 0);
    chk("s8_rst_dir", up_ndown, 1);
    cycles(2);
    reset = 1'b1;
    cycles(5);
    chk("s8_post_floor", current_floor, 0);
    chk("s8_post_moving", moving, 0);
    chk("s8_post_pending", pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
